// File: rtl/slave_reg.sv
// slave_reg: responder end of the bus register protocol.
//
// Accepts write address / write data / read address transactions, commits
// writes into a local register file and returns write responses and read
// data. Write and read channels are independent and may run concurrently.
//
// Optional feature macro: SLAVE_REG_STRB_EN
//   defined   -> write_strb port present, commit updates only enabled lanes
//   undefined -> no write_strb port, every commit writes the full word
//
// Ports:
//   clk, rst                     bus clock, asynchronous active-high reset
//   write_addr/_valid/_ready     write address channel
//   write_data/_strb/_valid/_ready  write data channel
//   write_resp/_valid/_ready     write response channel (00 OKAY, 10 SLVERR)
//   read_addr/_valid/_ready      read address channel
//   read_data/read_resp/read_data_valid/read_data_ready  read data channel
module slave_reg #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   write_addr,
  input  logic                    write_addr_valid,
  output logic                    write_addr_ready,
  input  logic [DATA_WIDTH-1:0]   write_data,
`ifdef SLAVE_REG_STRB_EN
  input  logic [DATA_WIDTH/8-1:0] write_strb,
`endif
  input  logic                    write_valid,
  output logic                    write_ready,
  output logic [1:0]              write_resp,
  output logic                    write_resp_valid,
  input  logic                    write_resp_ready,
  input  logic [ADDR_WIDTH-1:0]   read_addr,
  input  logic                    read_addr_valid,
  output logic                    read_addr_ready,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic [1:0]              read_resp,
  output logic                    read_data_valid,
  input  logic                    read_data_ready
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned LSB    = (NBYTES > 1) ? $clog2(NBYTES) : 0;
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate;
  rstate_t rstate;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Write-side holding registers: address and data arrive independently.
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [DATA_WIDTH-1:0] data_hold;
`ifdef SLAVE_REG_STRB_EN
  logic [NBYTES-1:0]     strb_hold;
  logic [NBYTES-1:0]     strb_eff;
`endif

  logic                  aw_hs;
  logic                  w_hs;
  logic                  r_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] addr_eff;
  logic [DATA_WIDTH-1:0] data_eff;
  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_sel;
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] new_word;
  logic [ADDR_WIDTH-1:0] r_word;
  logic                  r_in_range;
  logic [IDX_W-1:0]      r_sel;
  logic [DATA_WIDTH-1:0] r_value;

  assign aw_hs = write_addr_valid && write_addr_ready;
  assign w_hs  = write_valid && write_ready;
  assign r_hs  = read_addr_valid && read_addr_ready;

  // A freshly handshaken beat is used directly so the commit lands on the
  // same edge as the second of the two captures.
  assign addr_eff = aw_held ? addr_hold : write_addr;
  assign data_eff = w_held  ? data_hold : write_data;
`ifdef SLAVE_REG_STRB_EN
  assign strb_eff = w_held  ? strb_hold : write_strb;
`endif

  assign commit = (wstate == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

  // Word index decode; sub-word address bits are discarded by the shift.
  assign w_word     = addr_eff >> LSB;
  assign w_in_range = 32'(w_word) < NUM_REGS;
  assign w_sel      = w_word[IDX_W-1:0];

  assign r_word     = read_addr >> LSB;
  assign r_in_range = 32'(r_word) < NUM_REGS;
  assign r_sel      = r_word[IDX_W-1:0];
  assign r_value    = r_in_range ? regs[r_sel] : '0;

  // Byte-lane write mask.
  always_comb begin
    wmask = '1;
`ifdef SLAVE_REG_STRB_EN
    for (int b = 0; b < int'(NBYTES); b++) begin
      wmask[8*b +: 8] = {8{strb_eff[b]}};
    end
`endif
  end

  assign new_word = (regs[w_sel] & ~wmask) | (data_eff & wmask);

  // Register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (commit && w_in_range) begin
      regs[w_sel] <= new_word;
    end
  end

  // Write FSM: collect address and data, commit, hold response until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate           <= W_IDLE;
      write_addr_ready <= 1'b0;
      write_ready      <= 1'b0;
      write_resp_valid <= 1'b0;
      write_resp       <= RESP_OKAY;
      aw_held          <= 1'b0;
      w_held           <= 1'b0;
      addr_hold        <= '0;
      data_hold        <= '0;
`ifdef SLAVE_REG_STRB_EN
      strb_hold        <= '0;
`endif
    end else begin
      case (wstate)
        W_IDLE: begin
          if (commit) begin
            wstate           <= W_RESP;
            write_resp_valid <= 1'b1;
            write_resp       <= w_in_range ? RESP_OKAY : RESP_SLVERR;
            write_addr_ready <= 1'b0;
            write_ready      <= 1'b0;
            aw_held          <= 1'b0;
            w_held           <= 1'b0;
          end else begin
            if (aw_hs) begin
              aw_held   <= 1'b1;
              addr_hold <= write_addr;
            end
            if (w_hs) begin
              w_held    <= 1'b1;
              data_hold <= write_data;
`ifdef SLAVE_REG_STRB_EN
              strb_hold <= write_strb;
`endif
            end
            // Each ready stays low once its own beat is held.
            write_addr_ready <= !(aw_held || aw_hs);
            write_ready      <= !(w_held || w_hs);
          end
        end
        W_RESP: begin
          if (write_resp_ready) begin
            wstate           <= W_IDLE;
            write_resp_valid <= 1'b0;
            write_addr_ready <= 1'b1;
            write_ready      <= 1'b1;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM: capture data on the address handshake, hold until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate          <= R_IDLE;
      read_addr_ready <= 1'b0;
      read_data_valid <= 1'b0;
      read_data       <= '0;
      read_resp       <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (r_hs) begin
            rstate          <= R_DATA;
            read_data       <= r_value;
            read_resp       <= r_in_range ? RESP_OKAY : RESP_SLVERR;
            read_data_valid <= 1'b1;
            read_addr_ready <= 1'b0;
          end else begin
            read_addr_ready <= 1'b1;
          end
        end
        R_DATA: begin
          if (read_data_ready) begin
            rstate          <= R_IDLE;
            read_data_valid <= 1'b0;
            read_addr_ready <= 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_reg.sv
// Self-checking bench for slave_reg: directed transactions with literal
// expectations plus a transaction-level register model checked every cycle.
module tb_slave_reg;

`ifdef SLAVE_REG_STRB_EN
  localparam bit STRB_ON = 1'b1;
`else
  localparam bit STRB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  write_addr;
  logic        write_addr_valid;
  logic        write_addr_ready;
  logic [31:0] write_data;
  logic [3:0]  write_strb;
  logic        write_valid;
  logic        write_ready;
  logic [1:0]  write_resp;
  logic        write_resp_valid;
  logic        write_resp_ready;
  logic [7:0]  read_addr;
  logic        read_addr_valid;
  logic        read_addr_ready;
  logic [31:0] read_data;
  logic [1:0]  read_resp;
  logic        read_data_valid;
  logic        read_data_ready;

  int n_cmp = 0;
  int n_err = 0;

  slave_reg dut (
    .clk              (clk),
    .rst              (rst),
    .write_addr       (write_addr),
    .write_addr_valid (write_addr_valid),
    .write_addr_ready (write_addr_ready),
    .write_data       (write_data),
`ifdef SLAVE_REG_STRB_EN
    .write_strb       (write_strb),
`endif
    .write_valid      (write_valid),
    .write_ready      (write_ready),
    .write_resp       (write_resp),
    .write_resp_valid (write_resp_valid),
    .write_resp_ready (write_resp_ready),
    .read_addr        (read_addr),
    .read_addr_valid  (read_addr_valid),
    .read_addr_ready  (read_addr_ready),
    .read_data        (read_data),
    .read_resp        (read_resp),
    .read_data_valid  (read_data_valid),
    .read_data_ready  (read_data_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem [16];
  logic [33:0] rq [$];
  logic [1:0]  wq [$];
  bit          rv_pend, wv_pend, aw_done, w_done;
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_strb;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rq.delete(); wq.delete();
        rv_pend = 0; wv_pend = 0; aw_done = 0; w_done = 0;
      end else begin
        if (rv_pend) chk("rd_latency", read_data_valid, 1);
        if (wv_pend) chk("wr_latency", write_resp_valid, 1);
        rv_pend = 0; wv_pend = 0;
        if (read_data_valid) begin
          if (rq.size() == 0) chk("rd_unexpected", read_data_valid, 0);
          else begin
            chk("rd_data", read_data, rq[0][31:0]);
            chk("rd_resp", read_resp, rq[0][33:32]);
            if (read_data_ready) void'(rq.pop_front());
          end
        end
        if (write_resp_valid) begin
          if (wq.size() == 0) chk("wr_unexpected", write_resp_valid, 0);
          else begin
            chk("wr_resp", write_resp, wq[0]);
            if (write_resp_ready) void'(wq.pop_front());
          end
        end
        // Reads see the register file as it was before any same-edge write.
        if (read_addr_valid && read_addr_ready) begin
          if ((read_addr >> 2) < 16) rq.push_back({2'b00, mem[read_addr[5:2]]});
          else rq.push_back({2'b10, 32'h0});
          rv_pend = 1;
        end
        if (write_addr_valid && write_addr_ready) begin
          m_addr = write_addr; aw_done = 1;
        end
        if (write_valid && write_ready) begin
          m_data = write_data; m_strb = STRB_ON ? write_strb : 4'hF; w_done = 1;
        end
        if (aw_done && w_done) begin
          if ((m_addr >> 2) < 16) begin
            for (int b = 0; b < 4; b++)
              if (m_strb[b]) mem[m_addr[5:2]][8*b +: 8] = m_data[8*b +: 8];
            wq.push_back(2'b00);
          end else wq.push_back(2'b10);
          wv_pend = 1; aw_done = 0; w_done = 0;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drv_wdata(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    write_data = d; write_strb = s; write_valid = 1;
    do begin @(negedge clk); n++; end while (!write_ready && n < 20);
    chk("w_handshake", write_ready, 1);
    @(posedge clk); #1 write_valid = 0;
  endtask

  task automatic drv_waddr(input logic [7:0] a);
    int n = 0;
    write_addr = a; write_addr_valid = 1;
    do begin @(negedge clk); n++; end while (!write_addr_ready && n < 20);
    chk("aw_handshake", write_addr_ready, 1);
    @(posedge clk); #1 write_addr_valid = 0;
  endtask

  // gap: cycles between data and address; hold: cycles response ready held 0.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int gap, input int hold, input logic [1:0] er);
    write_resp_ready = (hold == 0);
    fork
      drv_wdata(d, s);
      begin
        repeat (gap) begin @(posedge clk); #1; end
        drv_waddr(a);
      end
    join
    @(negedge clk);
    chk("wr_valid_lit", write_resp_valid, 1);
    chk("wr_resp_lit", write_resp, er);
    for (int i = 0; i < hold; i++) begin
      chk("wr_hold_rdys", {write_addr_ready, write_ready}, 2'b00);
      @(posedge clk); #1;
      if (i == hold - 1) write_resp_ready = 1;
      @(negedge clk);
      chk("wr_hold_valid", write_resp_valid, 1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_done", {write_resp_valid, write_addr_ready, write_ready}, 3'b011);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [7:0] a, input int hold, input bit lit,
                         input logic [31:0] ed, input logic [1:0] er);
    int n = 0;
    read_data_ready = (hold == 0);
    read_addr = a; read_addr_valid = 1;
    do begin @(negedge clk); n++; end while (!read_addr_ready && n < 20);
    chk("ra_handshake", read_addr_ready, 1);
    @(posedge clk); #1 read_addr_valid = 0;
    @(negedge clk);
    chk("rd_valid_lit", read_data_valid, 1);
    if (lit) begin
      chk("rd_data_lit", read_data, ed);
      chk("rd_resp_lit", read_resp, er);
    end
    for (int i = 0; i < hold; i++) begin
      chk("rd_hold_ardy", read_addr_ready, 0);
      @(posedge clk); #1;
      if (i == hold - 1) read_data_ready = 1;
      @(negedge clk);
      chk("rd_hold_valid", read_data_valid, 1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_done", {read_data_valid, read_addr_ready}, 2'b01);
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1; write_addr = 0; write_addr_valid = 0; write_data = 0; write_strb = 4'hF;
    write_valid = 0; write_resp_ready = 1; read_addr = 0; read_addr_valid = 0;
    read_data_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdys", {write_addr_ready, write_ready, read_addr_ready}, 3'b000);
    chk("rst_valids", {write_resp_valid, read_data_valid}, 2'b00);
    chk("rst_rdata", read_data, 0);
    chk("rst_resps", {write_resp, read_resp}, 4'b0000);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rdys_pre_edge", {write_addr_ready, write_ready, read_addr_ready}, 3'b000);
    @(posedge clk); #1;
    chk("rdys_post_edge", {write_addr_ready, write_ready, read_addr_ready}, 3'b111);

    do_read(8'h0C, 0, 1, 32'h0, 2'b00);
    do_write(8'h08, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00);
    do_read(8'h08, 0, 1, 32'hDEADBEEF, 2'b00);
    do_write(8'h0C, 32'h12345678, 4'hF, 3, 3, 2'b00);
    do_read(8'h0C, 2, 1, 32'h12345678, 2'b00);
    do_write(8'h3E, 32'hCAFEF00D, 4'hF, 0, 0, 2'b00);
    do_read(8'h3D, 0, 1, 32'hCAFEF00D, 2'b00);
    do_write(8'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b10);
    do_read(8'h40, 0, 1, 32'h0, 2'b10);
    do_read(8'hFC, 0, 1, 32'h0, 2'b10);
    for (int i = 0; i < 16; i++) do_read(8'(i * 4), 0, 0, 32'h0, 2'b00);

    do_write(8'h08, 32'h11111111, 4'hF, 0, 0, 2'b00);
    fork
      do_write(8'h08, 32'h22222222, 4'hF, 0, 0, 2'b00);
      do_read(8'h08, 0, 1, 32'h11111111, 2'b00);
    join
    do_read(8'h08, 0, 1, 32'h22222222, 2'b00);

`ifdef SLAVE_REG_STRB_EN
    do_write(8'h04, 32'hAABBCCDD, 4'hF, 0, 0, 2'b00);
    do_write(8'h04, 32'h11223344, 4'b0101, 0, 0, 2'b00);
    do_read(8'h04, 0, 1, 32'hAA22CC44, 2'b00);
`endif

    // Abort a half-collected write with reset.
    drv_wdata(32'h99999999, 4'hF);
    rst = 1;
    @(negedge clk);
    chk("abort_rdys", {write_addr_ready, write_ready, read_addr_ready}, 3'b000);
    chk("abort_valids", {write_resp_valid, read_data_valid}, 2'b00);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    do_read(8'h08, 0, 1, 32'h0, 2'b00);
    do_write(8'h10, 32'hA5A5A5A5, 4'hF, 0, 0, 2'b00);
    do_read(8'h10, 0, 1, 32'hA5A5A5A5, 2'b00);

    repeat (2) @(posedge clk);
    chk("rq_drained", 64'(rq.size()), 0);
    chk("wq_drained", 64'(wq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/slave_reg.md
# slave_reg

Responder end of the bus register protocol: accepts write address/data and read address transactions from the bus master, commits writes into a local register file, and returns write responses and read data with valid/ready handshakes. Sits on the far side of the bus interface, one instance per addressable peripheral. Write and read channels run independently and concurrently.

## Interface

- ADDR_WIDTH, 8, byte address width
- DATA_WIDTH, 32, data width; multiple of 8
- NUM_REGS, 16, number of DATA_WIDTH registers; index = addr >> log2(DATA_WIDTH/8)

- clk  in  1  bus clock
- rst  in  1  reset, asynchronous, active-high
- write_addr  in  ADDR_WIDTH  write byte address
- write_addr_valid  in  1  write address valid
- write_addr_ready  out  1  write address accepted
- write_data  in  DATA_WIDTH  write data
- write_strb  in  DATA_WIDTH/8  byte enables (only with SLAVE_REG_STRB_EN)
- write_valid  in  1  write data valid
- write_ready  out  1  write data accepted
- write_resp  out  2  00 OKAY, 10 SLVERR
- write_resp_valid  out  1  write response valid
- write_resp_ready  in  1  master accepts response
- read_addr  in  ADDR_WIDTH  read byte address
- read_addr_valid  in  1  read address valid
- read_addr_ready  out  1  read address accepted
- read_data  out  DATA_WIDTH  read data
- read_resp  out  2  00 OKAY, 10 SLVERR
- read_data_valid  out  1  read data valid
- read_data_ready  in  1  master accepts read data

## Operation

- Handshake on any channel: transfer on rising clk edge where valid && ready both 1.
- Write address and write data captured independently into holding regs; each ready drops the cycle after its own capture, stays 0 until the response handshake completes.
- Write FSM: W_IDLE (collecting) -> W_RESP when both address and data held; on the W_RESP entry edge the write commits and write_resp_valid rises. W_RESP -> W_IDLE on write_resp_ready; both readies return to 1 on that same edge.
- Read FSM: R_IDLE -> R_DATA on read address handshake; read_data/read_resp registered on that edge, read_data_valid rises, read_addr_ready drops. R_DATA -> R_IDLE on read_data_ready.
- Out-of-range index (>= NUM_REGS): write discarded, write_resp = 10; read returns 0, read_resp = 10. Low address bits below word granularity ignored.
- read_data, read_resp, write_resp stable while their valid is 1 and ready is 0.
- Same-edge read capture and write commit to one register: read returns pre-write value.

## Timing

- Reset values: all registers 0; write_addr_ready, write_ready, read_addr_ready 0; write_resp_valid, read_data_valid 0; write_resp, read_resp 00; read_data 0; FSMs in idle.
- All three readies rise on the first clk edge after rst deasserts.
- Write latency: address and data same edge N -> write_resp_valid high after N (1 cycle). Data at N, address at N+k -> response after N+k.
- Read latency: address handshake at edge N -> read_data_valid high after N.
- Throughput: one write per 2 cycles, one read per 2 cycles with ready held high.
- rst asserted mid-transaction: immediate abort, all outputs and registers to reset values; pending response never issued.

## Configuration

- SLAVE_REG_STRB_EN defined: write_strb port present; only byte lanes with strb bit 1 updated on commit; strb captured with write data.
- Not defined: no write_strb port; every commit writes the full word.

## Test plan

- Reset release: readies 0 during rst, 1 one cycle after; read reg 3 -> read_data 0, read_resp 00.
- Write 0xDEADBEEF to addr 0x08 (addr and data same cycle), write_resp_ready 1 -> resp 00 one cycle later; read 0x08 -> 0xDEADBEEF.
- Data at cycle 2, address 0x0C at cycle 5, write_resp_ready held 0 for 3 cycles -> write_resp_valid held, write_addr_ready/write_ready 0 throughout; read 0x0C returns data.
- Write/read to addr 0x40 with NUM_REGS=16 -> write_resp 10, read_data 0, read_resp 10; registers 0-15 unchanged.
- Reg 2 = 0x11111111; write 0x22222222 to reg 2 committing on same edge as read address for reg 2 -> read_data 0x11111111; next read 0x22222222.
- With SLAVE_REG_STRB_EN: reg 1 = 0xAABBCCDD, write 0x11223344 strb 0101 -> reg 1 reads 0xAA22CC44.
